// File: rtl/mmss_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmss_timer_pkg
//  Description : Shared types and constants for the min/sec countdown timer
//                and the downstream binary-to-BCD stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package mmss_timer_pkg;

    // Width of the binary minute/second values handed to the BCD converter
    localparam int c_CNT_W = 8;

    // Highest seconds value; also the reload value on a minute borrow
    localparam logic [c_CNT_W-1:0] c_SEC_MAX = 8'd59;

    // Countdown control states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Saturate a loaded value to an upper limit
    function automatic logic [c_CNT_W-1:0] f_clamp(
        input logic [c_CNT_W-1:0] i_val,
        input logic [c_CNT_W-1:0] i_lim
    );
        return (i_val > i_lim) ? i_lim : i_val;
    endfunction

endpackage : mmss_timer_pkg
`default_nettype wire

// File: rtl/mmss_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : mmss_tick_gen
//  Description : Prescaler producing a one-cycle tick every CLK_HZ enabled
//                clock cycles. Synchronous clear overrides enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmss_tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int c_PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_PRE_W-1:0] c_LAST = c_PRE_W'(CLK_HZ - 1);

    logic [c_PRE_W-1:0] r_cnt;
    logic               w_last;

    assign w_last = (r_cnt == c_LAST);

    // The tick is only meaningful while counting; a held count never ticks.
    assign o_tick = i_en & w_last;

    // Count 0..CLK_HZ-1 while enabled, hold otherwise, clear on request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule : mmss_tick_gen
`default_nettype wire

// File: rtl/mmss_countdown_core.sv
`default_nettype none
// ============================================================================
//  Module      : mmss_countdown_core
//  Description : Minute/second countdown engine with load/start/stop/clear
//                control, internal 1 Hz prescaler and done signalling.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmss_countdown_core
    import mmss_timer_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int MAX_MIN = 99
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               start,
    input  logic               stop,
    input  logic               clear,
    input  logic [c_CNT_W-1:0] min_set,
    input  logic [c_CNT_W-1:0] sec_set,
    output logic [c_CNT_W-1:0] min_out,
    output logic [c_CNT_W-1:0] sec_out,
    output logic               running,
    output logic               done,
    output logic               done_pulse
);

    localparam logic [c_CNT_W-1:0] c_MIN_LIM = c_CNT_W'(MAX_MIN);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_min;
    logic [c_CNT_W-1:0] r_sec;
    logic [c_CNT_W-1:0] w_min_nxt;
    logic [c_CNT_W-1:0] w_sec_nxt;
    logic               r_running;
    logic               r_done;
    logic               r_done_pulse;
    logic               w_done_pulse_nxt;
    logic               w_pre_en;
    logic               w_pre_clr;
    logic               w_tick;
    logic               w_nonzero;
    logic               w_dec_zero;

    // A stop or clear in the tick cycle must swallow that tick and freeze
    // the prescaler, so both gate the enable directly.
    assign w_pre_en   = (r_state == ST_RUN) && !stop && !clear;
    assign w_nonzero  = (r_min != '0) || (r_sec != '0);
    // Only 0:01 decrements to 0:00; RUN is never entered at 0:00.
    assign w_dec_zero = (r_min == '0) && (r_sec == 8'd1);

    mmss_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_pre_en),
        .i_clr  (w_pre_clr),
        .o_tick (w_tick)
    );

    // Next state, next counter values and prescaler clear; clear > load > stop > start
    always_comb begin
        w_state_nxt      = r_state;
        w_min_nxt        = r_min;
        w_sec_nxt        = r_sec;
        w_pre_clr        = 1'b0;
        w_done_pulse_nxt = 1'b0;

        if (clear) begin
            w_state_nxt = ST_IDLE;
            w_min_nxt   = '0;
            w_sec_nxt   = '0;
            w_pre_clr   = 1'b1;
        end else if (load && (r_state != ST_RUN)) begin
            w_state_nxt = ST_IDLE;
            w_min_nxt   = f_clamp(min_set, c_MIN_LIM);
            w_sec_nxt   = f_clamp(sec_set, c_SEC_MAX);
        end else if (stop && (r_state == ST_RUN)) begin
            w_state_nxt = ST_PAUSED;
        end else if (start && w_nonzero &&
                     ((r_state == ST_IDLE) || (r_state == ST_PAUSED))) begin
            w_state_nxt = ST_RUN;
            w_pre_clr   = 1'b1;
        end else if (w_tick) begin
            if (r_sec != '0) begin
                w_sec_nxt = r_sec - 1'b1;
            end else begin
                w_sec_nxt = c_SEC_MAX;
                w_min_nxt = r_min - 1'b1;
            end
            if (w_dec_zero) begin
                w_state_nxt      = ST_DONE;
                w_done_pulse_nxt = 1'b1;
            end
        end
    end

    // State register plus registered status flags decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_running    <= 1'b0;
            r_done       <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_running    <= (w_state_nxt == ST_RUN);
            r_done       <= (w_state_nxt == ST_DONE);
            r_done_pulse <= w_done_pulse_nxt;
        end
    end

    // Minute and second counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min <= '0;
            r_sec <= '0;
        end else begin
            r_min <= w_min_nxt;
            r_sec <= w_sec_nxt;
        end
    end

    assign min_out    = r_min;
    assign sec_out    = r_sec;
    assign running    = r_running;
    assign done       = r_done;
    assign done_pulse = r_done_pulse;

endmodule : mmss_countdown_core
`default_nettype wire
